// File: rtl/seg7_scan_driver_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared constants and helpers for the multiplexed seven-segment display path.
//   SEG_DIG_0..SEG_DIG_9 : active-low segment codes, order {a,b,c,d,e,f,g}
//   SEG_BLANK            : all seven segments dark
//   DP_ON / DP_OFF       : active-low decimal-point levels
//   clog2()              : ceil(log2(value)), never less than 1, so a counter
//                          or index sized with it always has at least one bit
// -----------------------------------------------------------------------------
package seg7_pkg;

  localparam logic [6:0] SEG_DIG_0 = 7'b0000001;
  localparam logic [6:0] SEG_DIG_1 = 7'b1001111;
  localparam logic [6:0] SEG_DIG_2 = 7'b0010010;
  localparam logic [6:0] SEG_DIG_3 = 7'b0000110;
  localparam logic [6:0] SEG_DIG_4 = 7'b1001100;
  localparam logic [6:0] SEG_DIG_5 = 7'b0100100;
  localparam logic [6:0] SEG_DIG_6 = 7'b0100000;
  localparam logic [6:0] SEG_DIG_7 = 7'b0001111;
  localparam logic [6:0] SEG_DIG_8 = 7'b0000000;
  localparam logic [6:0] SEG_DIG_9 = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic DP_ON  = 1'b0;
  localparam logic DP_OFF = 1'b1;

  // Width needed to hold 0..value-1; a single-valued range still gets one bit.
  function automatic int clog2(input int value);
    int result;
    result = 1;
    for (int i = 1; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        result = i + 1;
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver_if
// Bundles the display data inputs and the scanned display outputs.
//   load        : 1-cycle strobe, capture bcd_in/dp_mask/blink_mask/lz_en
//   bcd_in      : packed BCD, digit i = bcd_in[4i+3:4i], digit 0 rightmost
//   dp_mask     : 1 = light decimal point of digit i
//   blink_mask  : 1 = digit i blinks
//   lz_en       : 1 = enable leading-zero blanking
//   an          : active-low anode enables, one per digit
//   seg         : active-low {a,b,c,d,e,f,g,dp}
//   scan_idx    : index of the digit currently driven
// master = data source (and display observer), slave = the scan driver.
// -----------------------------------------------------------------------------
interface seg7_scan_driver_if #(
  parameter int NUM_DIGITS = 8
);
  import seg7_pkg::*;

  localparam int IDX_W = clog2(NUM_DIGITS);

  logic                    load;
  logic [4*NUM_DIGITS-1:0] bcd_in;
  logic [NUM_DIGITS-1:0]   dp_mask;
  logic [NUM_DIGITS-1:0]   blink_mask;
  logic                    lz_en;
  logic [NUM_DIGITS-1:0]   an;
  logic [7:0]              seg;
  logic [IDX_W-1:0]        scan_idx;

  modport master (
    output load, bcd_in, dp_mask, blink_mask, lz_en,
    input  an, seg, scan_idx
  );

  modport slave (
    input  load, bcd_in, dp_mask, blink_mask, lz_en,
    output an, seg, scan_idx
  );

endinterface

// File: rtl/seg7_scan_driver_bcd_to_seg7.sv
// -----------------------------------------------------------------------------
// bcd_to_seg7
// Combinational BCD to active-low seven-segment decoder. Codes 10..15 are not
// valid BCD and decode to SEG_BLANK.
//   i_bcd : 4-bit BCD digit
//   o_seg : active-low segments {a,b,c,d,e,f,g}
// -----------------------------------------------------------------------------
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  // Segment lookup.
  always_comb begin
    case (i_bcd)
      4'd0:    o_seg = SEG_DIG_0;
      4'd1:    o_seg = SEG_DIG_1;
      4'd2:    o_seg = SEG_DIG_2;
      4'd3:    o_seg = SEG_DIG_3;
      4'd4:    o_seg = SEG_DIG_4;
      4'd5:    o_seg = SEG_DIG_5;
      4'd6:    o_seg = SEG_DIG_6;
      4'd7:    o_seg = SEG_DIG_7;
      4'd8:    o_seg = SEG_DIG_8;
      4'd9:    o_seg = SEG_DIG_9;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
// Time-multiplexed common-anode display driver. A shadow register holds the
// digits/masks; each digit is driven for CLK_DIV cycles in turn, with
// leading-zero blanking, blinking and invalid-code blanking. Outputs are
// registered one cycle after the scan index.
//   clk   : system clock
//   rst_n : synchronous active-low reset
//   bus   : seg7_scan_driver_if.slave (load/data inputs, an/seg/scan_idx outputs)
// The interface instance must be built with the same NUM_DIGITS.
// -----------------------------------------------------------------------------
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int CLK_DIV     = 50000,
  parameter int BLINK_TICKS = 250,
  parameter int MIN_DIGITS  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  seg7_scan_driver_if.slave  bus
);

  localparam int IDX_W = clog2(NUM_DIGITS);
  localparam int PRE_W = clog2(CLK_DIV);
  localparam int BLK_W = clog2(BLINK_TICKS);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_TICKS - 1);
  // One extra bit so MIN_DIGITS == NUM_DIGITS (e.g. 16) is still representable.
  localparam logic [IDX_W:0]   IDX_MIN  = (IDX_W + 1)'(MIN_DIGITS);

  logic [PRE_W-1:0]        r_presc;
  logic [IDX_W-1:0]        r_idx;
  logic [BLK_W-1:0]        r_blink_cnt;
  logic                    r_blink_phase;

  logic [4*NUM_DIGITS-1:0] r_bcd;
  logic [NUM_DIGITS-1:0]   r_dp;
  logic [NUM_DIGITS-1:0]   r_blink;
  logic                    r_lz;

  logic [NUM_DIGITS-1:0]   r_an;
  logic [7:0]              r_seg;
  logic [IDX_W-1:0]        r_scan_idx;

  logic                    w_tick;
  logic [3:0]              w_digit;
  logic [6:0]              w_code;
  logic                    w_carry;
  logic [NUM_DIGITS-1:0]   w_hi_clear;
  logic                    w_lz_blank;
  logic [7:0]              w_pattern;

  assign w_tick  = (r_presc == PRE_LAST);
  assign w_digit = r_bcd[{r_idx, 2'b00} +: 4];

  bcd_to_seg7 u_dec (
    .i_bcd (w_digit),
    .o_seg (w_code)
  );

  // Prescaler, scan index and blink timing.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_presc       <= {PRE_W{1'b0}};
      r_idx         <= {IDX_W{1'b0}};
      r_blink_cnt   <= {BLK_W{1'b0}};
      r_blink_phase <= 1'b1;
    end else if (w_tick) begin
      r_presc <= {PRE_W{1'b0}};
      r_idx   <= (r_idx == IDX_LAST) ? {IDX_W{1'b0}} : r_idx + {{(IDX_W-1){1'b0}}, 1'b1};
      if (r_blink_cnt == BLK_LAST) begin
        r_blink_cnt   <= {BLK_W{1'b0}};
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_blink_cnt   <= r_blink_cnt + {{(BLK_W-1){1'b0}}, 1'b1};
      end
    end else begin
      r_presc <= r_presc + {{(PRE_W-1){1'b0}}, 1'b1};
    end
  end

  // Shadow registers; independent of the scan so a load on a tick still lands.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bcd   <= {(4*NUM_DIGITS){1'b0}};
      r_dp    <= {NUM_DIGITS{1'b0}};
      r_blink <= {NUM_DIGITS{1'b0}};
      r_lz    <= 1'b0;
    end else if (bus.load) begin
      r_bcd   <= bus.bcd_in;
      r_dp    <= bus.dp_mask;
      r_blink <= bus.blink_mask;
      r_lz    <= bus.lz_en;
    end else begin
      r_bcd   <= r_bcd;
      r_dp    <= r_dp;
      r_blink <= r_blink;
      r_lz    <= r_lz;
    end
  end

  // w_hi_clear[i] = digits i..top are all zero with no dp set among them.
  always_comb begin
    w_carry    = 1'b1;
    w_hi_clear = {NUM_DIGITS{1'b0}};
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_carry       = w_carry & (r_bcd[4*i +: 4] == 4'd0) & ~r_dp[i];
      w_hi_clear[i] = w_carry;
    end
  end

  // Pattern for the digit under the scan index; blink dark phase wins.
  always_comb begin
    w_lz_blank = r_lz & ({1'b0, r_idx} >= IDX_MIN) & w_hi_clear[r_idx];
    if (r_blink[r_idx] & ~r_blink_phase) begin
      w_pattern = 8'hFF;
    end else if (w_lz_blank) begin
      w_pattern = 8'hFF;
    end else begin
      // Invalid codes arrive here already blanked by the decoder; dp still shows.
      w_pattern = {w_code, (r_dp[r_idx] ? DP_ON : DP_OFF)};
    end
  end

  // Registered output stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_an       <= {NUM_DIGITS{1'b1}};
      r_seg      <= 8'hFF;
      r_scan_idx <= {IDX_W{1'b0}};
    end else begin
      r_an       <= ~({{(NUM_DIGITS-1){1'b0}}, 1'b1} << r_idx);
      r_seg      <= w_pattern;
      r_scan_idx <= r_idx;
    end
  end

  assign bus.an       = r_an;
  assign bus.seg      = r_seg;
  assign bus.scan_idx = r_scan_idx;

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

  localparam int ND = 4;
  localparam int CD = 4;
  localparam int BT = 2;
  localparam int MD = 1;

  logic clk;
  logic rst_n;

  seg7_scan_driver_if #(.NUM_DIGITS(ND)) bus ();

  seg7_scan_driver #(
    .NUM_DIGITS  (ND),
    .CLK_DIV     (CD),
    .BLINK_TICKS (BT),
    .MIN_DIGITS  (MD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       chk_idx;
    logic [3:0] an;
    logic [7:0] seg;
    logic [1:0] idx;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Reference state: cycles since reset release and the displayed data.
  int          n = 0;
  logic [15:0] m_bcd   = 16'h0000;
  logic [3:0]  m_dp    = 4'h0;
  logic [3:0]  m_blink = 4'h0;
  logic        m_lz    = 1'b0;

  function automatic logic [6:0] seg_code(input int d);
    case (d)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      9: return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic int digit_of(input int j);
    return int'((m_bcd >> (4 * j)) & 16'h000F);
  endfunction

  function automatic logic [7:0] model_seg(input int idx, input bit vis);
    bit lzb;
    if (m_blink[idx] && !vis) return 8'hFF;
    if (m_lz && idx >= MD) begin
      lzb = 1'b1;
      for (int j = idx; j < ND; j++) begin
        if (digit_of(j) != 0 || m_dp[j]) lzb = 1'b0;
      end
      if (lzb) return 8'hFF;
    end
    return {seg_code(digit_of(idx)), ~m_dp[idx]};
  endfunction

  // Drive one clock of stimulus and queue what the DUT must show after it.
  task automatic step(input logic rn, input logic ld, input logic [15:0] b,
                      input logic [3:0] d, input logic [3:0] bl, input logic lz);
    exp_t e;
    int   slot;
    int   idx;
    bit   vis;
    rst_n          = rn;
    bus.load       = ld;
    bus.bcd_in     = b;
    bus.dp_mask    = d;
    bus.blink_mask = bl;
    bus.lz_en      = lz;
    if (!rn) begin
      e.chk_idx = 1'b0;
      e.an      = 4'hF;
      e.seg     = 8'hFF;
      e.idx     = 2'd0;
    end else begin
      slot      = n / CD;
      idx       = slot % ND;
      vis       = ((slot / BT) % 2) == 0;
      e.chk_idx = 1'b1;
      e.an      = ~(4'b0001 << idx);
      e.seg     = model_seg(idx, vis);
      e.idx     = 2'(idx);
    end
    exp_q.push_back(e);
    @(posedge clk);
    if (!rn) begin
      n       = 0;
      m_bcd   = 16'h0000;
      m_dp    = 4'h0;
      m_blink = 4'h0;
      m_lz    = 1'b0;
    end else begin
      n = n + 1;
      if (ld) begin
        m_bcd   = b;
        m_dp    = d;
        m_blink = bl;
        m_lz    = lz;
      end
    end
    #1;
  endtask

  task automatic idle(input int cycles);
    for (int k = 0; k < cycles; k++) begin
      step(1'b1, 1'b0, 16'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
    end
  endtask

  task automatic load(input logic [15:0] b, input logic [3:0] d,
                      input logic [3:0] bl, input logic lz);
    step(1'b1, 1'b1, b, d, bl, lz);
  endtask

  function automatic logic [15:0] rand_bcd();
    logic [15:0] v;
    for (int j = 0; j < ND; j++) begin
      v[4*j +: 4] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
    end
    return v;
  endfunction

  // Scoreboard monitor: one expectation per clock edge, sampled on negedge.
  always @(negedge clk) begin
    exp_t e;
    cyc = cyc + 1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks = checks + 1;
      if (bus.an !== e.an || bus.seg !== e.seg || (e.chk_idx && bus.scan_idx !== e.idx)) begin
        errors = errors + 1;
        $display("FAIL display cyc=%0d: got an=%b seg=%b idx=%0d, expected an=%b seg=%b idx=%0d",
                 cyc, bus.an, bus.seg, bus.scan_idx, e.an, e.seg, e.idx);
      end
    end
  end

  initial begin
    // Reset held 3 cycles with a load that must be ignored.
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 16'h9999, 4'hF, 4'hF, 1'b1);
    idle(20);
    // Plain digits.
    load(16'h1234, 4'b0100, 4'b0000, 1'b0);
    idle(17);
    // Leading zeros.
    load(16'h0007, 4'b0000, 4'b0000, 1'b1);
    idle(17);
    load(16'h0000, 4'b0000, 4'b0000, 1'b1);
    idle(17);
    load(16'h0005, 4'b0100, 4'b0000, 1'b1);
    idle(17);
    // Invalid code with dp.
    load(16'h00A5, 4'b0010, 4'b0000, 1'b0);
    idle(17);
    // Blink.
    load(16'h8888, 4'b0000, 4'b0001, 1'b0);
    idle(48);
    // Mid-scan reset while digit 2 is shown, load ignored under reset.
    while (!(((n / CD) % ND) == 2 && (n % CD) == 1)) idle(1);
    step(1'b0, 1'b1, 16'h7777, 4'hF, 4'h0, 1'b0);
    idle(20);
    // Load coincident with a scan tick.
    while ((n % CD) != CD - 1) idle(1);
    load(16'h9630, 4'b1000, 4'b0000, 1'b1);
    idle(20);
    // Randomized traffic with occasional resets.
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 199) == 0) begin
        step(1'b0, 1'($urandom), rand_bcd(), 4'($urandom), 4'($urandom), 1'($urandom));
      end else if ($urandom_range(0, 7) == 0) begin
        load(rand_bcd(), ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0,
             ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0, 1'($urandom));
      end else begin
        idle(1);
      end
    end
    // Drain the scoreboard with a bounded wait.
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) begin
      @(negedge clk);
      #1;
    end
    if (exp_q.size() > 0) begin
      errors = errors + 1;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
